// File: rtl/rvsteel_board_pkg.sv
// Shared definitions for the board reset/halt sequencer: FSM state encoding
// and the counter-width helper used by the sequencer and its debouncers.
package rvsteel_board_pkg;

   typedef enum logic [1:0] {
      POR_HOLD = 2'd0,
      RUN      = 2'd1,
      ASSERT   = 2'd2,
      HOLD     = 2'd3
   } seq_state_t;

   // Width of a counter that must reach n-1; never narrower than one bit.
   function automatic int counter_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/button_debouncer.sv
// One push-button input path: polarity normalisation, 2-flop synchroniser,
// counter debouncer and a one-cycle pulse on each released->pressed change.
module button_debouncer
   import rvsteel_board_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES    = 500000,
   parameter bit BUTTON_ACTIVE_HIGH = 1'b1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_pin,
   output logic o_state,
   output logic o_press
);

   localparam int               CNT_W    = counter_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             w_norm;
   logic [1:0]       r_sync;
   logic [CNT_W-1:0] r_cnt;
   logic             r_stable;
   logic             r_stable_d;

   assign w_norm = BUTTON_ACTIVE_HIGH ? i_pin : ~i_pin;

   // The counter only advances while the synced level disagrees with the
   // stable state, so any agreeing sample restarts the qualification window.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync     <= 2'b00;
         r_cnt      <= '0;
         r_stable   <= 1'b0;
         r_stable_d <= 1'b0;
      end else begin
         r_sync     <= {r_sync[0], w_norm};
         r_stable_d <= r_stable;
         if (r_sync[1] == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_stable <= ~r_stable;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign o_state = r_stable;
   assign o_press = r_stable & ~r_stable_d;

endmodule

// File: rtl/board_reset_sequencer.sv
// Sequences SoC reset and halt from debounced push-buttons: power-on hold,
// minimum reset pulse width, and level or toggle halt control.
module board_reset_sequencer
   import rvsteel_board_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES    = 500000,
   parameter int RESET_HOLD_CYCLES  = 16,
   parameter bit HALT_TOGGLE        = 1'b0,
   parameter bit BUTTON_ACTIVE_HIGH = 1'b1
) (
   input  logic clock,
   input  logic reset_n,
   input  logic reset_button,
   input  logic halt_button,
   output logic soc_reset,
   output logic soc_halt,
   output logic soc_ready
);

   localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > RESET_HOLD_CYCLES) ?
                               DEBOUNCE_CYCLES : RESET_HOLD_CYCLES;
   localparam int               CNT_W     = counter_width(MAX_CYCLES);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD_CYCLES - 1);

   logic [1:0]       r_rst_sync;
   logic             w_rst_n;
   logic             w_rst_state;
   logic             w_rst_press;
   logic             w_halt_state;
   logic             w_halt_press;
   seq_state_t       r_state;
   seq_state_t       w_state_nxt;
   logic [CNT_W-1:0] r_hold_cnt;
   logic [CNT_W-1:0] w_hold_cnt_nxt;
   logic             r_halt_tog;
   logic             w_halt_tog_nxt;
   logic             w_halt_nxt;
   logic             r_soc_reset;
   logic             r_soc_halt;
   logic             r_soc_ready;

   // Assertion reaches every flop at once; release is delayed two edges.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_rst_sync <= 2'b00;
      end else begin
         r_rst_sync <= {r_rst_sync[0], 1'b1};
      end
   end

   assign w_rst_n = r_rst_sync[1];

   button_debouncer #(
      .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
      .BUTTON_ACTIVE_HIGH (BUTTON_ACTIVE_HIGH)
   ) u_reset_button (
      .i_clk   (clock),
      .i_rst_n (w_rst_n),
      .i_pin   (reset_button),
      .o_state (w_rst_state),
      .o_press (w_rst_press)
   );

   button_debouncer #(
      .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
      .BUTTON_ACTIVE_HIGH (BUTTON_ACTIVE_HIGH)
   ) u_halt_button (
      .i_clk   (clock),
      .i_rst_n (w_rst_n),
      .i_pin   (halt_button),
      .o_state (w_halt_state),
      .o_press (w_halt_press)
   );

   always_ff @(posedge clock or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state     <= POR_HOLD;
         r_hold_cnt  <= '0;
         r_halt_tog  <= 1'b0;
         r_soc_reset <= 1'b1;
         r_soc_halt  <= 1'b0;
         r_soc_ready <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_hold_cnt  <= w_hold_cnt_nxt;
         r_halt_tog  <= w_halt_tog_nxt;
         r_soc_reset <= (w_state_nxt != RUN);
         r_soc_halt  <= w_halt_nxt;
         r_soc_ready <= (w_state_nxt == RUN);
      end
   end

   // The hold counter is zero whenever it is not actively counting, so every
   // entry into HOLD starts a full hold window.
   always_comb begin
      w_state_nxt    = r_state;
      w_hold_cnt_nxt = '0;
      w_halt_tog_nxt = r_halt_tog;
      case (r_state)
         POR_HOLD: begin
            if (r_hold_cnt == HOLD_LAST) begin
               w_state_nxt = RUN;
            end else begin
               w_hold_cnt_nxt = r_hold_cnt + CNT_W'(1);
            end
         end
         RUN: begin
            if (w_rst_press) begin
               w_state_nxt = ASSERT;
            end else if (w_halt_press) begin
               w_halt_tog_nxt = ~r_halt_tog;
            end
         end
         ASSERT: begin
            if (!w_rst_state) begin
               w_state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (w_rst_press) begin
               w_state_nxt = ASSERT;
            end else if (r_hold_cnt == HOLD_LAST) begin
               w_state_nxt = RUN;
            end else begin
               w_hold_cnt_nxt = r_hold_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = POR_HOLD;
         end
      endcase

      if ((w_state_nxt == ASSERT) || (w_state_nxt == POR_HOLD)) begin
         w_halt_tog_nxt = 1'b0;
      end

      w_halt_nxt = 1'b0;
      if (w_state_nxt == RUN) begin
         w_halt_nxt = HALT_TOGGLE ? w_halt_tog_nxt : w_halt_state;
      end
   end

   assign soc_reset = r_soc_reset;
   assign soc_halt  = r_soc_halt;
   assign soc_ready = r_soc_ready;

endmodule

// File: tb/tb_board_reset_sequencer.sv
// Bench for board_reset_sequencer: a level-mode active-high instance and a
// toggle-mode active-low instance driven from the same button stimulus.
module tb_board_reset_sequencer;

   localparam int DEB  = 4;
   localparam int HOLD = 8;

   localparam int PH_POR      = 0;
   localparam int PH_RUN      = 1;
   localparam int PH_ASSERTED = 2;
   localparam int PH_HOLD     = 3;

   logic clock        = 1'b0;
   logic reset_n      = 1'b1;
   logic reset_button = 1'b0;
   logic halt_button  = 1'b0;
   logic l_reset, l_halt, l_ready;
   logic t_reset, t_halt, t_ready;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: pin history, debounced levels and the sequencer phase.
   int m_rel;
   int m_phase;
   int m_timer;
   bit m_tog;
   bit m_pipe0 [2];
   bit m_pipe1 [2];
   bit m_deb [2];
   bit m_deb_prev [2];
   int m_run [2];
   bit e_reset, e_ready, e_halt_lvl, e_halt_tog;

   always #5 clock = ~clock;

   board_reset_sequencer #(
      .DEBOUNCE_CYCLES    (DEB),
      .RESET_HOLD_CYCLES  (HOLD),
      .HALT_TOGGLE        (1'b0),
      .BUTTON_ACTIVE_HIGH (1'b1)
   ) u_dut_level (
      .clock        (clock),
      .reset_n      (reset_n),
      .reset_button (reset_button),
      .halt_button  (halt_button),
      .soc_reset    (l_reset),
      .soc_halt     (l_halt),
      .soc_ready    (l_ready)
   );

   board_reset_sequencer #(
      .DEBOUNCE_CYCLES    (DEB),
      .RESET_HOLD_CYCLES  (HOLD),
      .HALT_TOGGLE        (1'b1),
      .BUTTON_ACTIVE_HIGH (1'b0)
   ) u_dut_toggle (
      .clock        (clock),
      .reset_n      (reset_n),
      .reset_button (~reset_button),
      .halt_button  (~halt_button),
      .soc_reset    (t_reset),
      .soc_halt     (t_halt),
      .soc_ready    (t_ready)
   );

   function automatic void model_reset();
      m_rel   = 0;
      m_phase = PH_POR;
      m_timer = 0;
      m_tog   = 1'b0;
      for (int b = 0; b < 2; b++) begin
         m_pipe0[b]    = 1'b0;
         m_pipe1[b]    = 1'b0;
         m_deb[b]      = 1'b0;
         m_deb_prev[b] = 1'b0;
         m_run[b]      = 0;
      end
      e_reset    = 1'b1;
      e_ready    = 1'b0;
      e_halt_lvl = 1'b0;
      e_halt_tog = 1'b0;
   endfunction

   // Advance the model by one rising edge using the values held before it.
   function automatic void model_edge();
      bit rp, hp, rdeb, hdeb;
      bit pins [2];
      if (m_rel < 2) begin
         m_rel++;
         return;
      end
      rp   = m_deb[0] & ~m_deb_prev[0];
      hp   = m_deb[1] & ~m_deb_prev[1];
      rdeb = m_deb[0];
      hdeb = m_deb[1];
      case (m_phase)
         PH_POR: begin
            m_timer++;
            if (m_timer == HOLD) begin
               m_phase = PH_RUN;
               m_timer = 0;
            end
         end
         PH_RUN: begin
            if (rp) begin
               m_phase = PH_ASSERTED;
               m_tog   = 1'b0;
            end else if (hp) begin
               m_tog = ~m_tog;
            end
         end
         PH_ASSERTED: begin
            if (!rdeb) begin
               m_phase = PH_HOLD;
               m_timer = 0;
            end
         end
         default: begin
            if (rp) begin
               m_phase = PH_ASSERTED;
            end else begin
               m_timer++;
               if (m_timer == HOLD) begin
                  m_phase = PH_RUN;
                  m_timer = 0;
               end
            end
         end
      endcase
      e_reset    = (m_phase != PH_RUN);
      e_ready    = (m_phase == PH_RUN);
      e_halt_lvl = e_ready & hdeb;
      e_halt_tog = e_ready & m_tog;

      pins[0] = reset_button;
      pins[1] = halt_button;
      for (int b = 0; b < 2; b++) begin
         m_deb_prev[b] = m_deb[b];
         if (m_pipe1[b] != m_deb[b]) m_run[b]++;
         else m_run[b] = 0;
         if (m_run[b] == DEB) begin
            m_deb[b] = ~m_deb[b];
            m_run[b] = 0;
         end
         m_pipe1[b] = m_pipe0[b];
         m_pipe0[b] = pins[b];
      end
   endfunction

   task automatic expect_bit(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_model(input string ph);
      expect_bit({ph, "_lvl_reset"}, l_reset, e_reset);
      expect_bit({ph, "_lvl_ready"}, l_ready, e_ready);
      expect_bit({ph, "_lvl_halt"},  l_halt,  e_halt_lvl);
      expect_bit({ph, "_tog_reset"}, t_reset, e_reset);
      expect_bit({ph, "_tog_ready"}, t_ready, e_ready);
      expect_bit({ph, "_tog_halt"},  t_halt,  e_halt_tog);
   endtask

   // Called at a falling edge: drive pins, take one rising edge, check.
   task automatic step(input logic rb, input logic hb, input string ph);
      reset_button = rb;
      halt_button  = hb;
      @(posedge clock);
      model_edge();
      @(negedge clock);
      check_model(ph);
   endtask

   task automatic check_reset_values(input string tag);
      expect_bit({tag, "_lvl_reset"}, l_reset, 1'b1);
      expect_bit({tag, "_lvl_halt"},  l_halt,  1'b0);
      expect_bit({tag, "_lvl_ready"}, l_ready, 1'b0);
      expect_bit({tag, "_tog_reset"}, t_reset, 1'b1);
      expect_bit({tag, "_tog_halt"},  t_halt,  1'b0);
      expect_bit({tag, "_tog_ready"}, t_ready, 1'b0);
   endtask

   // Two synchroniser edges, then HOLD cycles of power-on hold.
   task automatic por_sequence(input string tag);
      for (int k = 1; k <= 12; k++) begin
         step(1'b0, 1'b0, tag);
         expect_bit({tag, "_reset"}, l_reset, (k < 2 + HOLD));
         expect_bit({tag, "_ready"}, t_ready, (k >= 2 + HOLD));
         expect_bit({tag, "_halt"},  t_halt,  1'b0);
      end
   endtask

   // A p-cycle clean press: rise at 3+DEB, fall after release latency + HOLD.
   task automatic reset_press(input int p, input string tag);
      int fall;
      fall = p + DEB + 3 + HOLD;
      for (int k = 1; k <= fall + 2; k++) begin
         step(k <= p, 1'b0, tag);
         expect_bit({tag, "_reset"}, l_reset, (k >= 3 + DEB) && (k < fall));
         expect_bit({tag, "_ready"}, t_ready, !((k >= 3 + DEB) && (k < fall)));
      end
   endtask

   initial begin
      int   rb_left;
      int   hb_left;
      logic rb_v;
      logic hb_v;
      rb_left = 0;
      hb_left = 0;
      rb_v    = 1'b0;
      hb_v    = 1'b0;

      // Let the reset synchroniser settle high so assertion is a real edge.
      repeat (3) @(negedge clock);
      reset_n = 1'b0;
      model_reset();
      #1;
      check_reset_values("rst_vals");
      @(negedge clock);
      reset_n = 1'b1;
      por_sequence("por");

      for (int k = 1; k <= 12; k++) begin
         step(k <= 3, 1'b0, "glitch");
         expect_bit("glitch_reset", l_reset, 1'b0);
      end

      reset_press(4, "press4");
      reset_press(20, "press20");

      for (int j = 0; j < 3; j++) begin
         for (int k = 1; k <= 14; k++) step(1'b0, k <= 5, "tog");
         expect_bit("tog_seq", t_halt, (j != 1));
      end
      for (int k = 1; k <= 22; k++) begin
         step(k <= 4, 1'b0, "tog_rst");
         if (((k >= 5) && (k <= 8)) || (k == 22)) expect_bit("tog_clear", t_halt, (k < 7));
      end

      for (int k = 1; k <= 24; k++) begin
         step(k <= 6, k <= 6, "both");
         expect_bit("both_reset", l_reset, (k >= 7) && (k < 6 + DEB + 3 + HOLD));
         expect_bit("both_lvl_halt", l_halt, 1'b0);
         expect_bit("both_tog_halt", t_halt, 1'b0);
      end

      for (int k = 1; k <= 20; k++) begin
         step(1'b0, k <= 10, "level");
         expect_bit("level_halt", l_halt, (k >= 7) && (k < 17));
      end

      for (int k = 1; k <= 13; k++) step(k <= 4, 1'b0, "to_hold");
      expect_bit("hold_reset", l_reset, 1'b1);
      reset_n = 1'b0;
      model_reset();
      #1;
      check_reset_values("mid_hold");
      @(negedge clock);
      reset_n = 1'b1;
      por_sequence("por2");

      for (int i = 0; i < 400; i++) begin
         if (rb_left == 0) begin
            rb_v    = ($urandom_range(0, 3) == 0);
            rb_left = $urandom_range(1, 12);
         end
         if (hb_left == 0) begin
            hb_v    = ($urandom_range(0, 2) == 0);
            hb_left = $urandom_range(1, 12);
         end
         rb_left--;
         hb_left--;
         step(rb_v, hb_v, "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/board_reset_sequencer.md
Name: board_reset_sequencer

Overview:
Board-level controller that sequences the SoC reset and halt inputs from raw push-buttons. It replaces ad-hoc single-flop button sampling with synchronised, counter-debounced inputs. It also enforces a power-on reset, a guaranteed minimum reset pulse width, and either level or toggle halt control. It sits between board pins and the rvsteel_soc reset/halt ports, clocked by the SoC clock.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a debounced button changes state (10 ms at 50 MHz); must be >= 1
RESET_HOLD_CYCLES, 16, minimum cycles soc_reset stays high after power-on or button release; must be >= 1
HALT_TOGGLE, 0, 0 = soc_halt follows debounced halt button (level); 1 = each debounced halt press flips soc_halt
BUTTON_ACTIVE_HIGH, 1, 1 = button pressed when pin high; 0 = pressed when pin low

Ports:
clock  input  1  SoC clock, all logic on rising edge
reset_n  input  1  asynchronous active-low board reset
reset_button  input  1  raw, asynchronous reset push-button pin
halt_button  input  1  raw, asynchronous halt push-button pin
soc_reset  output  1  active-high reset to SoC, registered
soc_halt  output  1  active-high halt to SoC, registered
soc_ready  output  1  high while the sequencer is in RUN

Behaviour:
- One clock. reset_n is asynchronous active-low: assertion takes effect immediately; release is synchronous to clock via internal 2-flop reset synchroniser.
- Reset values: soc_reset=1, soc_halt=0, soc_ready=0, debounced states=released, all counters=0, FSM=POR_HOLD.
- Input path per button:
  - Polarity normalisation per BUTTON_ACTIVE_HIGH.
  - 2-flop synchroniser.
  - Debouncer: counter clears whenever the synced value equals the stable state. Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1 and the input still differs, the stable state flips and the counter clears.
  - Debounced state changes exactly 2+DEBOUNCE_CYCLES edges after a clean pin change.
  - Glitches shorter than DEBOUNCE_CYCLES synced cycles never change the stable state.
- Counter width is $clog2 of the larger parameter. Counters never wrap; they clear on reaching terminal count.
- Press event: a one-cycle pulse on each released->pressed transition of a debounced state.
- FSM states:
  - POR_HOLD: soc_reset=1. Hold counter runs; after RESET_HOLD_CYCLES cycles go to RUN.
  - RUN: soc_reset=0, soc_ready=1. On reset press go to ASSERT.
  - ASSERT: soc_reset=1. Remain while debounced reset is pressed; on release clear the hold counter and go to HOLD.
  - HOLD: soc_reset=1. After RESET_HOLD_CYCLES cycles go to RUN. A new reset press in HOLD returns to ASSERT with the counter cleared.
- soc_reset and soc_ready are registered from the next state: soc_reset rises 1 cycle after the reset press pulse, i.e. 3+DEBOUNCE_CYCLES edges after the pin press.
- Halt:
  - Level mode: soc_halt = debounced halt, registered, 1 cycle after the debounced change.
  - Toggle mode: soc_halt flips on each halt press event.
  - In both modes soc_halt is forced 0 in every state except RUN.
  - The toggle register clears on entry to ASSERT or POR_HOLD.
  - Halt press events outside RUN are discarded.
- Simultaneous reset and halt press events in the same cycle: reset wins and the halt event is discarded.
- Reset mid-operation: reset_n assertion in any state returns immediately to reset values and POR_HOLD; the full power-on hold is re-run.
- soc_reset never produces a high pulse shorter than RESET_HOLD_CYCLES+1 cycles.

Decomposition:
- Shared package rvsteel_board_pkg holds:
  - FSM state encoding constants: POR_HOLD=2'd0, RUN=2'd1, ASSERT=2'd2, HOLD=2'd3.
  - A clog2-based counter-width helper.
- Sub-module button_debouncer: polarity normalisation, synchroniser, debounce counter, and press-event pulse. Parameters are DEBOUNCE_CYCLES and BUTTON_ACTIVE_HIGH. It is instantiated twice.
- The FSM and halt logic live in board_reset_sequencer.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and RESET_HOLD_CYCLES=8.
- Power-on: release reset_n at cycle 0 with buttons idle -> soc_reset stays 1 through POR_HOLD, drops after the sync plus 8 hold cycles; soc_ready rises on the same edge; soc_halt stays 0 throughout.
- Glitch rejection: 3-cycle pulse on reset_button in RUN -> soc_reset stays 0; then a 4-cycle clean press -> soc_reset rises exactly 7 edges after the pin rise.
- Reset hold: hold reset_button 20 cycles then release -> soc_reset high for the whole press, plus debounce latency, plus exactly 8 HOLD cycles; soc_ready stays 0 meanwhile.
- Halt toggle (HALT_TOGGLE=1): three clean halt presses in RUN -> soc_halt sequence 1,0,1. Then a reset press -> soc_halt 0 immediately on ASSERT entry and still 0 after return to RUN.
- Simultaneous and level (HALT_TOGGLE=0): press both buttons on the same cycle -> reset sequence runs and soc_halt stays 0. Then in RUN hold halt 10 cycles -> soc_halt high from edge 7 until 7 edges after release.
- Async reset mid-HOLD: assert reset_n at HOLD cycle 3 -> all outputs at reset values immediately (soc_reset=1, soc_halt=0, soc_ready=0); after release the full 8-cycle POR_HOLD runs.
